bitvec_index_scanner: RTL and testbench

BITVEC_INDEX_SCANNER -- requirements
Module: bitvec_index_scanner

---
 rtl/bitvec_index_scanner_if.sv | 50 +++++
 rtl/bitvec_index_scanner.sv | 150 +++++++++++++++
 tb/tb_bitvec_index_scanner.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bitvec_index_scanner_if.sv
// Handshake bundle for the bit-vector index scanner.
// The master side loads vectors, aborts scans and accepts indices.
// The slave side is the scanner itself.
interface bitvec_index_scanner_if #(
    parameter int WIDTH_I = 8,
    parameter int WIDTH_O = 3
);
    // Request side, driven by the master.
    logic               load_i;
    logic [WIDTH_I-1:0] data_i;
    logic               abort_i;
    logic               ready_i;

    // Result side, driven by the scanner.
    logic               valid_o;
    logic [WIDTH_O-1:0] index_o;
    logic               last_o;
    logic               done_o;
    logic               busy_o;
    logic [WIDTH_O:0]   count_o;
    logic               onehot_o;

    modport master (
        output load_i,
        output data_i,
        output abort_i,
        output ready_i,
        input  valid_o,
        input  index_o,
        input  last_o,
        input  done_o,
        input  busy_o,
        input  count_o,
        input  onehot_o
    );

    modport slave (
        input  load_i,
        input  data_i,
        input  abort_i,
        input  ready_i,
        output valid_o,
        output index_o,
        output last_o,
        output done_o,
        output busy_o,
        output count_o,
        output onehot_o
    );
endinterface

// File: rtl/bitvec_index_scanner.sv
// Bit-vector index scanner.
// A loaded vector is held in a pending register; while scanning, the index
// of the lowest pending set bit is presented and removed on each handshake.
// The population count and one-hot status of the loaded vector are held
// until the next accepted load.
module bitvec_index_scanner #(
    parameter int WIDTH_I = 8,
    parameter int WIDTH_O = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    bitvec_index_scanner_if.slave   bus
);

    // Reject configurations the index or count outputs cannot represent.
    generate
        if ((WIDTH_I < 2) || (WIDTH_I > 256) || (WIDTH_O < $clog2(WIDTH_I))) begin : g_cfg_error
            $error("bitvec_index_scanner: illegal WIDTH_I/WIDTH_O combination");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [WIDTH_I-1:0] ONE_I = WIDTH_I'(1);
    localparam logic [WIDTH_O:0]   ONE_C = (WIDTH_O + 1)'(1);

    // Number of set bits in a vector; the count is one bit wider than an
    // index so that an all-ones vector of WIDTH_I = 2**WIDTH_O still fits.
    function automatic logic [WIDTH_O:0] popcount(input logic [WIDTH_I-1:0] v);
        logic [WIDTH_O:0] c;
        c = '0;
        for (int i = 0; i < WIDTH_I; i++) begin
            c = c + {{WIDTH_O{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Mask of all bit positions whose binary index has bit b set; used to
    // encode a one-hot vector into a binary index with one OR per index bit.
    function automatic logic [WIDTH_I-1:0] index_bit_mask(input int b);
        logic [WIDTH_I-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH_I; i++) begin
            m[i] = ((i >> b) & 1) != 0;
        end
        return m;
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH_I-1:0] pending_q, pending_d;
    logic [WIDTH_O:0]   count_q, count_d;
    logic               onehot_q, onehot_d;
    logic               done_q, done_d;

    logic               emit;
    logic [WIDTH_I-1:0] lowest_mask;
    logic [WIDTH_I-1:0] pending_rest;
    logic               single_pending;
    logic [WIDTH_O-1:0] lowest_idx;
    logic [WIDTH_O:0]   data_pop;

    assign emit = (state_q == EMIT);

    // Isolate the lowest set bit, and the pending vector with it removed.
    assign lowest_mask    = pending_q & (~pending_q + ONE_I);
    assign pending_rest   = pending_q & (pending_q - ONE_I);
    assign single_pending = (pending_q != '0) && (pending_rest == '0);

    // Binary-encode the isolated lowest bit, one index bit per generate slice.
    generate
        for (genvar gi = 0; gi < WIDTH_O; gi++) begin : g_enc
            localparam logic [WIDTH_I-1:0] SEL_MASK = index_bit_mask(gi);
            assign lowest_idx[gi] = |(lowest_mask & SEL_MASK);
        end
    endgenerate

    assign data_pop = popcount(bus.data_i);

    // Next-state logic: load in IDLE, drain or abort in EMIT.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        onehot_d  = onehot_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_i) begin
                    pending_d = bus.data_i;
                    count_d   = data_pop;
                    onehot_d  = (data_pop == ONE_C);
                    if (bus.data_i != '0) begin
                        state_d = EMIT;
                    end else begin
                        // An empty vector completes immediately.
                        done_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (bus.abort_i) begin
                    // Abort takes priority over a simultaneous handshake.
                    pending_d = '0;
                    state_d   = IDLE;
                end else if (bus.ready_i) begin
                    pending_d = pending_rest;
                    if (single_pending) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            count_q   <= '0;
            onehot_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            onehot_q  <= onehot_d;
            done_q    <= done_d;
        end
    end

    // Outputs are zero outside EMIT; they only change on an edge, so they
    // hold stable while the consumer stalls.
    assign bus.valid_o  = emit;
    assign bus.index_o  = emit ? lowest_idx : '0;
    assign bus.last_o   = emit & single_pending;
    assign bus.busy_o   = (state_q != IDLE);
    assign bus.done_o   = done_q;
    assign bus.count_o  = count_q;
    assign bus.onehot_o = onehot_q;

endmodule

// File: tb/tb_bitvec_index_scanner.sv
// Self-checking bench for bitvec_index_scanner (WIDTH_I=8, WIDTH_O=3).
// A queue-based reference model tracks the indices still to be emitted and
// is compared against every output after every clock edge.
module tb_bitvec_index_scanner;

    localparam int WI = 8;
    localparam int WO = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bitvec_index_scanner_if #(.WIDTH_I(WI), .WIDTH_O(WO)) bus ();

    bitvec_index_scanner #(.WIDTH_I(WI), .WIDTH_O(WO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: remaining indices in ascending order, held count,
    // held one-hot flag and the expected done pulse.
    int exp_q[$];
    int m_count  = 0;
    bit m_onehot = 1'b0;
    bit m_done   = 1'b0;

    typedef struct {
        logic [7:0] data;
        int         exp_count;
        bit         exp_onehot;
        int         exp_first;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit ld, input logic [7:0] d, input bit ab, input bit rdy, input bit r);
        int n;
        m_done = 1'b0;
        if (r) begin
            exp_q.delete();
            m_count  = 0;
            m_onehot = 1'b0;
        end else if (exp_q.size() != 0) begin
            if (ab) begin
                exp_q.delete();
            end else if (rdy) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_done = 1'b1;
            end
        end else if (ld) begin
            n = 0;
            for (int i = 0; i < WI; i++) begin
                if (d[i]) begin
                    exp_q.push_back(i);
                    n++;
                end
            end
            m_count  = n;
            m_onehot = (n == 1);
            if (n == 0) m_done = 1'b1;
        end
    endtask

    task automatic check_outputs();
        bit v;
        v = (exp_q.size() != 0);
        check("valid",  bus.valid_o,  v);
        check("index",  bus.index_o,  v ? exp_q[0] : 0);
        check("last",   bus.last_o,   exp_q.size() == 1);
        check("busy",   bus.busy_o,   v);
        check("done",   bus.done_o,   m_done);
        check("count",  bus.count_o,  m_count);
        check("onehot", bus.onehot_o, m_onehot);
    endtask

    // One clock: drive inputs, advance the model at the edge, check after it.
    task automatic cycle(input bit ld, input logic [7:0] d, input bit ab, input bit rdy, input bit r);
        bus.load_i  = ld;
        bus.data_i  = d;
        bus.abort_i = ab;
        bus.ready_i = rdy;
        rst         = r;
        @(posedge clk);
        model_edge(ld, d, ab, rdy, r);
        #1;
        check_outputs();
    endtask

    // Drain with ready high; returns the number of handshakes seen.
    task automatic drain(output int n);
        int guard;
        n = 0;
        guard = 0;
        while (bus.busy_o && guard < 20) begin
            if (bus.valid_o) n++;
            cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        check("drain_idle", bus.busy_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seq34[4];
        bit r_ld, r_ab, r_rdy, r_rst;
        logic [7:0] r_d;

        vecs[0] = '{8'b1010_0110, 4, 1'b0, 1};
        vecs[1] = '{8'b0000_1000, 1, 1'b1, 3};
        vecs[2] = '{8'h00,        0, 1'b0, 0};
        vecs[3] = '{8'hFF,        8, 1'b0, 0};
        vecs[4] = '{8'h01,        1, 1'b1, 0};
        vecs[5] = '{8'h80,        1, 1'b1, 7};
        vecs[6] = '{8'h20,        1, 1'b1, 5};
        vecs[7] = '{8'b1100_0000, 2, 1'b0, 6};
        vecs[8] = '{8'h7E,        6, 1'b0, 1};
        vecs[9] = '{8'h90,        2, 1'b0, 4};

        // Reset state.
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
        check("rst_valid", bus.valid_o, 0);
        check("rst_busy",  bus.busy_o,  0);
        check("rst_count", bus.count_o, 0);
        check("rst_done",  bus.done_o,  0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Table-driven single loads.
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, vecs[k].data, 1'b0, 1'b1, 1'b0);
            $display("load data=%02h count=%0d onehot=%0d", vecs[k].data, bus.count_o, bus.onehot_o);
            check("tbl_count",  bus.count_o,  vecs[k].exp_count);
            check("tbl_onehot", bus.onehot_o, vecs[k].exp_onehot);
            check("tbl_first",  bus.index_o,  vecs[k].exp_first);
            check("tbl_busy",   bus.busy_o,   vecs[k].exp_count != 0);
            drain(n);
            check("tbl_emitted", n, vecs[k].exp_count);
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end

        // 1010_0110 with ready high: 1,2,5,7 back to back, done after.
        seq34 = '{1, 2, 5, 7};
        cycle(1'b1, 8'b1010_0110, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("s34_index", bus.index_o, seq34[k]);
            check("s34_last",  bus.last_o,  k == 3);
            cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        check("s34_done",   bus.done_o,   1);
        check("s34_count",  bus.count_o,  4);
        check("s34_onehot", bus.onehot_o, 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("s34_done_end", bus.done_o, 0);

        // Single bit: index 3 with last, done after the handshake.
        cycle(1'b1, 8'b0000_1000, 1'b0, 1'b0, 1'b0);
        check("s35_index", bus.index_o, 3);
        check("s35_last",  bus.last_o,  1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("s35_done",  bus.done_o,  1);
        check("s35_onehot", bus.onehot_o, 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Empty vector: immediate done, never busy.
        cycle(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        check("s36_done",  bus.done_o,  1);
        check("s36_valid", bus.valid_o, 0);
        check("s36_busy",  bus.busy_o,  0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("s36_done_end", bus.done_o, 0);

        // All ones with a 3-cycle stall and an ignored mid-scan load.
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("s37_stall_idx", bus.index_o, 0);
        cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        check("s37_stall_idx", bus.index_o, 0);
        check("s37_count", bus.count_o, 8);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("s37_stall_valid", bus.valid_o, 1);
        for (int k = 0; k < 8; k++) begin
            check("s37_index", bus.index_o, k);
            cycle((k == 4), 8'h03, 1'b0, 1'b1, 1'b0);
        end
        check("s37_done", bus.done_o, 1);
        check("s37_count_end", bus.count_o, 8);

        // Abort together with the first handshake of 1100_0000.
        cycle(1'b1, 8'b1100_0000, 1'b0, 1'b1, 1'b0);
        check("s38_index", bus.index_o, 6);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check("s38_busy",  bus.busy_o,  0);
        check("s38_done",  bus.done_o,  0);
        check("s38_count", bus.count_o, 2);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("s38_done_late", bus.done_o, 0);

        // Abort on the last handshake suppresses done.
        cycle(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check("abort_last_done", bus.done_o, 0);

        // Reset mid-scan with 3 bits pending, then a normal scan.
        cycle(1'b1, 8'b0000_1110, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
        check("s39_busy",  bus.busy_o,  0);
        check("s39_count", bus.count_o, 0);
        check("s39_index", bus.index_o, 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("s39_done",  bus.done_o,  0);
        cycle(1'b1, 8'b0000_0101, 1'b0, 1'b1, 1'b0);
        check("s39_first", bus.index_o, 0);
        drain(n);
        check("s39_emitted", n, 2);

        // Randomised traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            r_ld  = ($urandom_range(0, 3) == 0);
            r_d   = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r_d = r_d & 8'($urandom);
            r_ab  = ($urandom_range(0, 15) == 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_rst = ($urandom_range(0, 127) == 0);
            cycle(r_ld, r_d, r_ab, r_rdy, r_rst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
